// File: rtl/dog_animator_pkg.sv
// Shared types and constants for the dog sprite: FSM states, frame indices,
// sprite size, and saturating 10-bit helpers.
package dog_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WALK,
        ST_SNIFF,
        ST_JUMP_UP,
        ST_JUMP_DOWN,
        ST_HIDDEN,
        ST_RISE,
        ST_HOLD,
        ST_FALL
    } dog_state_t;

    localparam logic [4:0] FR_WALK0     = 5'd0;
    localparam logic [4:0] FR_WALK1     = 5'd1;
    localparam logic [4:0] FR_WALK2     = 5'd2;
    localparam logic [4:0] FR_WALK3     = 5'd3;
    localparam logic [4:0] FR_SNIFF0    = 5'd4;
    localparam logic [4:0] FR_SNIFF1    = 5'd5;
    localparam logic [4:0] FR_JUMP_UP   = 5'd6;
    localparam logic [4:0] FR_JUMP_DOWN = 5'd7;
    localparam logic [4:0] FR_HOLD      = 5'd8;
    localparam logic [4:0] FR_LAUGH0    = 5'd9;
    localparam logic [4:0] FR_LAUGH1    = 5'd10;

    localparam int DOG_W = 110;
    localparam int DOG_H = 86;

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10] ? 10'h3ff : s[9:0];
    endfunction

    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? 10'd0 : a - b;
    endfunction

endpackage

// File: rtl/dog_animator_if.sv
// Event inputs and sprite outputs of the dog animator.
interface dog_animator_if;
    logic       round_start;
    logic       duck_hit;
    logic       duck_escaped;
    logic [9:0] hit_x;
    logic [9:0] Dog_X;
    logic [9:0] Dog_Y;
    logic [4:0] Frame;
    logic       Dog_Hidden;
    logic       dog_done;

    modport master (output round_start, duck_hit, duck_escaped, hit_x,
                    input  Dog_X, Dog_Y, Frame, Dog_Hidden, dog_done);
    modport slave  (input  round_start, duck_hit, duck_escaped, hit_x,
                    output Dog_X, Dog_Y, Frame, Dog_Hidden, dog_done);
endinterface

// File: rtl/dog_animator_frame_tick_sync.sv
// Brings the vsync-rate frame_clk into the Clk domain and emits a one-Clk
// tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    // [1:0] is the synchroniser, [2] the edge-detect delay
    logic [2:0] sync;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) sync <= '0;
        else        sync <= {sync[1:0], frame_clk};
    end

    assign tick = sync[1] & ~sync[2];
endmodule

// File: rtl/dog_animator.sv
// Dog sprite sequencer: intro walk/sniff/jump, then a pop-up per duck outcome,
// with all motion paced by the frame-rate tick.
module dog_animator
    import dog_pkg::*;
#(
    parameter logic [9:0] WALK_START_X = 10'd0,
    parameter logic [9:0] WALK_END_X   = 10'd260,
    parameter logic [9:0] GROUND_Y     = 10'd340,
    parameter logic [9:0] GRASS_Y      = 10'd380,
    parameter logic [9:0] JUMP_PEAK_Y  = 10'd250,
    parameter logic [9:0] POP_Y        = 10'd300,
    parameter int         WALK_STEP    = 2,
    parameter int         JUMP_STEP    = 3,
    parameter int         POP_STEP     = 2,
    parameter int         ANIM_DIV     = 6,
    parameter int         SNIFF_TICKS  = 60,
    parameter int         HOLD_TICKS   = 45,
    parameter logic [9:0] MAX_X        = 10'd530
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    dog_animator_if.slave  bus
);
    localparam logic [7:0] ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [7:0] SNIFF_LAST = 8'(SNIFF_TICKS - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);

    dog_state_t state;
    logic [9:0] x, y, pend_x;
    logic [4:0] frame;
    logic       hidden, done, pend_vld, pend_hit, tick;
    logic [7:0] anim_cnt, hold_cnt;
    logic       anim_wrap;
    logic [9:0] x_walk, y_jup, y_jdn, y_pup, y_pdn;

    frame_tick_sync u_sync (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .tick(tick));

    assign anim_wrap = (anim_cnt == ANIM_LAST);
    assign x_walk    = sat_add(x, 10'(WALK_STEP));
    assign y_jup     = sat_sub(y, 10'(JUMP_STEP));
    assign y_jdn     = sat_add(y, 10'(JUMP_STEP));
    assign y_pup     = sat_sub(y, 10'(POP_STEP));
    assign y_pdn     = sat_add(y, 10'(POP_STEP));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            x        <= WALK_START_X;
            y        <= GROUND_Y;
            frame    <= FR_WALK0;
            hidden   <= 1'b0;
            done     <= 1'b0;
            pend_vld <= 1'b0;
            pend_hit <= 1'b0;
            pend_x   <= '0;
            anim_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            // single-entry buffer; the hit wins a same-cycle tie
            if (!pend_vld && (bus.duck_hit || bus.duck_escaped)) begin
                pend_vld <= 1'b1;
                pend_hit <= bus.duck_hit;
                pend_x   <= bus.hit_x;
            end
            if (bus.round_start) begin
                state    <= ST_WALK;
                x        <= WALK_START_X;
                y        <= GROUND_Y;
                frame    <= FR_WALK0;
                hidden   <= 1'b0;
                pend_vld <= 1'b0;
                anim_cnt <= '0;
                hold_cnt <= '0;
            end else if (state == ST_HIDDEN && pend_vld) begin
                x        <= (pend_x > MAX_X) ? MAX_X : pend_x;
                hidden   <= 1'b0;
                frame    <= pend_hit ? FR_HOLD : FR_LAUGH0;
                pend_vld <= 1'b0;
                anim_cnt <= '0;
                state    <= ST_RISE;
            end else if (tick) begin
                anim_cnt <= anim_wrap ? '0 : anim_cnt + 8'd1;
                case (state)
                    ST_IDLE: ;
                    ST_WALK: begin
                        if (x_walk >= WALK_END_X) begin
                            x        <= WALK_END_X;
                            frame    <= FR_SNIFF0;
                            anim_cnt <= '0;
                            hold_cnt <= '0;
                            state    <= ST_SNIFF;
                        end else begin
                            x <= x_walk;
                            if (anim_wrap) frame <= (frame == FR_WALK3) ? FR_WALK0 : frame + 5'd1;
                        end
                    end
                    ST_SNIFF: begin
                        if (hold_cnt == SNIFF_LAST) begin
                            frame    <= FR_JUMP_UP;
                            anim_cnt <= '0;
                            state    <= ST_JUMP_UP;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                            if (anim_wrap) frame <= (frame == FR_SNIFF0) ? FR_SNIFF1 : FR_SNIFF0;
                        end
                    end
                    ST_JUMP_UP: begin
                        if (y_jup <= JUMP_PEAK_Y) begin
                            y        <= JUMP_PEAK_Y;
                            frame    <= FR_JUMP_DOWN;
                            anim_cnt <= '0;
                            state    <= ST_JUMP_DOWN;
                        end else y <= y_jup;
                    end
                    ST_JUMP_DOWN: begin
                        if (y_jdn >= GRASS_Y) begin
                            y        <= GRASS_Y;
                            hidden   <= 1'b1;
                            anim_cnt <= '0;
                            state    <= ST_HIDDEN;
                        end else y <= y_jdn;
                    end
                    ST_HIDDEN: y <= GRASS_Y;
                    ST_RISE: begin
                        if (y_pup <= POP_Y) begin
                            y        <= POP_Y;
                            anim_cnt <= '0;
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end else y <= y_pup;
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            anim_cnt <= '0;
                            state    <= ST_FALL;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                            // only the laugh animates; the held duck is a still frame
                            if (anim_wrap && frame != FR_HOLD)
                                frame <= (frame == FR_LAUGH0) ? FR_LAUGH1 : FR_LAUGH0;
                        end
                    end
                    ST_FALL: begin
                        if (y_pdn >= GRASS_Y) begin
                            y        <= GRASS_Y;
                            hidden   <= 1'b1;
                            done     <= 1'b1;
                            anim_cnt <= '0;
                            state    <= ST_HIDDEN;
                        end else y <= y_pdn;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.Dog_X      = x;
    assign bus.Dog_Y      = y;
    assign bus.Frame      = frame;
    assign bus.Dog_Hidden = hidden;
    assign bus.dog_done   = done;
endmodule

// File: tb/tb_dog_animator.sv
// Directed bench for dog_animator: intro sequence, pop-ups, event buffer,
// async reset and mid-sequence restart.
module tb_dog_animator;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic frame_clk = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_seen = 0;

    dog_animator_if bus();
    dog_animator dut (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus));

    always #5 Clk = ~Clk;
    always @(negedge Clk) if (bus.dog_done) done_seen <= done_seen + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey, input int ef, input int eh);
        chk({tag, "_x"}, 32'(bus.Dog_X), ex);
        chk({tag, "_y"}, 32'(bus.Dog_Y), ey);
        chk({tag, "_frame"}, 32'(bus.Frame), ef);
        chk({tag, "_hidden"}, 32'(bus.Dog_Hidden), eh);
    endtask

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        clk1();
        frame_clk = 1'b1;
        repeat (4) clk1();
        frame_clk = 1'b0;
        repeat (4) clk1();
    endtask

    task automatic pulse(input bit rs, input bit hit, input bit esc, input logic [9:0] px);
        clk1();
        bus.round_start = rs; bus.duck_hit = hit; bus.duck_escaped = esc; bus.hit_x = px;
        clk1();
        bus.round_start = 1'b0; bus.duck_hit = 1'b0; bus.duck_escaped = 1'b0;
    endtask

    // evt=1 injects a hit+escape tie during WALK and a late escape during SNIFF
    task automatic run_intro(input bit evt);
        for (int t = 1; t <= 130; t++) begin
            do_tick();
            if (t == 1) chk("walk_t1_x", 32'(bus.Dog_X), 2);
            if (t == 129) begin
                chk("walk_t129_x", 32'(bus.Dog_X), 258);
                chk("walk_t129_frame", 32'(bus.Frame), 1);
            end
            if (evt && t == 5) pulse(1'b0, 1'b1, 1'b1, 10'd150);
        end
        chk_out("sniff_entry", 260, 340, 4, 0);
        for (int k = 1; k <= 60; k++) begin
            do_tick();
            if (k < 60) chk("sniff_frame", 32'(bus.Frame), 4 + (k / 6) % 2);
            if (evt && k == 10) pulse(1'b0, 1'b0, 1'b1, 10'd400);
        end
        chk_out("jump_up_entry", 260, 340, 6, 0);
        for (int t = 1; t <= 30; t++) begin
            do_tick();
            if (t == 29) chk_out("jump_up_t29", 260, 253, 6, 0);
        end
        chk_out("jump_peak", 260, 250, 7, 0);
        for (int t = 1; t <= 44; t++) begin
            do_tick();
            if (t == 43) chk_out("jump_down_t43", 260, 379, 7, 0);
        end
        if (evt) chk_out("intro_end_serviced", 150, 380, 8, 0);
        else     chk_out("intro_end_hidden", 260, 380, 7, 1);
    endtask

    task automatic run_pop(input int f0, input bit laugh, input int abort_at);
        int d0;
        int ex;
        ex = 32'(bus.Dog_X);
        for (int t = 1; t <= 40; t++) begin
            do_tick();
            if (t == 39) chk_out("rise_t39", ex, 302, f0, 0);
        end
        chk_out("rise_top", ex, 300, f0, 0);
        for (int k = 1; k <= 45; k++) begin
            do_tick();
            if (k < 45) begin
                chk("hold_frame", 32'(bus.Frame), laugh ? 9 + (k / 6) % 2 : 8);
                chk("hold_y", 32'(bus.Dog_Y), 300);
            end
            if (k == abort_at) return;
        end
        chk("fall_entry_y", 32'(bus.Dog_Y), 300);
        d0 = done_seen;
        for (int t = 1; t <= 40; t++) begin
            do_tick();
            if (t == 39) begin
                chk_out("fall_t39", ex, 378, f0, 0);
                chk("done_before_end", done_seen - d0, 0);
            end
        end
        chk_out("fall_end", ex, 380, f0, 1);
        chk("done_width", done_seen - d0, 1);
        chk("done_low_after", 32'(bus.dog_done), 0);
    endtask

    initial begin
        bus.round_start = 1'b0; bus.duck_hit = 1'b0; bus.duck_escaped = 1'b0; bus.hit_x = '0;
        repeat (3) clk1();
        chk_out("reset", 0, 340, 0, 0);
        chk("reset_done", 32'(bus.dog_done), 0);
        Reset = 1'b1;
        clk1();

        pulse(1'b1, 1'b0, 1'b0, 10'd0);
        chk_out("start", 0, 340, 0, 0);
        for (int t = 1; t <= 50; t++) begin
            do_tick();
            chk("walk_x", 32'(bus.Dog_X), 2 * t);
            chk("walk_frame", 32'(bus.Frame), (t / 6) % 4);
        end

        @(posedge Clk);
        #3 Reset = 1'b0;
        #1 chk_out("async_reset", 0, 340, 0, 0);
        clk1();
        Reset = 1'b1;
        repeat (10) do_tick();
        chk_out("idle_hold", 0, 340, 0, 0);

        pulse(1'b1, 1'b0, 1'b0, 10'd0);
        run_intro(1'b0);
        repeat (3) do_tick();
        chk_out("hidden_wait", 260, 380, 7, 1);
        pulse(1'b0, 1'b1, 1'b0, 10'd600);
        clk1();
        chk_out("hit_clamp", 530, 380, 8, 0);
        run_pop(8, 1'b0, 0);

        pulse(1'b1, 1'b0, 1'b0, 10'd0);
        run_intro(1'b1);
        run_pop(8, 1'b0, 0);

        pulse(1'b0, 1'b0, 1'b1, 10'd200);
        clk1();
        chk_out("esc_service", 200, 380, 9, 0);
        run_pop(9, 1'b1, 30);
        pulse(1'b0, 1'b1, 1'b0, 10'd100);
        pulse(1'b1, 1'b0, 1'b0, 10'd0);
        chk_out("abort", 0, 340, 0, 0);
        run_intro(1'b0);
        repeat (3) clk1();
        chk_out("pending_cleared", 260, 380, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
